if_prefetch_buffer: RTL
=======================

Name: if_prefetch_buffer

Overview:
- Instruction-fetch prefetch stage between the instruction ROM and the decode stage of the CPU core.
- Owns the fetch PC and drives the ROM chip-enable and address each cycle.
- Captures returned instructions, with their PCs, into a small FIFO and presents them to decode through a valid/ready handshake.
- Supports redirect (jump/branch) with a full flush of prefetched entries.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction word width.
- RESET_PC, 0, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset: 0 = reset asserted.
- rom_ce_o  output  1  ROM chip enable; 1 = read requested this cycle.
- rom_addr_o  output  ADDR_W  ROM read address; equals the fetch PC.
- rom_data_i  input  DATA_W  ROM read data; combinational response to rom_ce_o/rom_addr_o in the same cycle.
- jump_i  input  1  redirect request from execute; single-cycle pulse.
- jump_addr_i  input  ADDR_W  redirect target; bits [1:0] ignored and treated as 0.
- inst_valid_o  output  1  FIFO head holds a valid instruction.
- inst_o  output  DATA_W  instruction at the FIFO head.
- pc_o  output  ADDR_W  PC of the instruction at the FIFO head.
- inst_ready_i  input  1  decode accepts the head entry this cycle.

Behaviour:
- State:
  - fetch_pc (ADDR_W)
  - FIFO storage of DEPTH x {pc, inst}
  - rd_ptr, wr_ptr: log2(DEPTH) bits, wrap modulo DEPTH
  - count: 0..DEPTH
- Reset (rst=0), asynchronous, takes effect immediately:
  - fetch_pc = RESET_PC; rd_ptr = wr_ptr = 0; count = 0.
  - Outputs while in reset: rom_ce_o=0, rom_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0.
- Reset mid-operation discards all FIFO contents. The first fetch follows the first rising edge after rst deasserts.
- Fetch request (combinational from registered state and jump_i):
  - rom_ce_o = rst & (count < DEPTH) & ~jump_i.
  - rom_addr_o = fetch_pc at all times.
- Push, when rom_ce_o=1 at the rising edge:
  - Write {fetch_pc, rom_data_i} to FIFO[wr_ptr].
  - wr_ptr += 1; fetch_pc += 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000).
- Output:
  - inst_valid_o = (count != 0).
  - inst_o and pc_o = FIFO[rd_ptr] when count != 0, else 0.
- Pop, when inst_valid_o & inst_ready_i & ~jump_i at the rising edge: rd_ptr += 1.
- Count update: count += push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - A pop while full (count = DEPTH) does not enable a same-cycle push; rom_ce_o is already 0 that cycle. The push occurs on the next cycle.
- Latency:
  - ROM access to inst_valid_o = 1 cycle.
  - Sustained throughput = 1 instruction per cycle while inst_ready_i=1.
- Redirect, when jump_i=1 at the rising edge. It has priority over push and pop:
  - count = 0; rd_ptr = wr_ptr = 0.
  - fetch_pc = {jump_addr_i[ADDR_W-1:2], 2'b00}.
  - No push (rom_ce_o=0 in that cycle); no pop.
  - Next cycle: inst_valid_o=0 and rom_ce_o=1 with rom_addr_o = target.
  - Cycle after that: inst_valid_o=1 with pc_o = target.
- Back-to-back jump_i pulses: the last one wins; each flushes again.
- Empty with inst_ready_i=1: no pop; pointers and count unchanged.
- No X propagation: inst_o and pc_o are forced to 0 when empty.

Test Plan:
- Reset then fill: rst 0->1, RESET_PC=0, inst_ready_i=0.
  - Required: rom_ce_o=1 with rom_addr_o = 0x0, 0x4, 0x8, 0xC on cycles 1-4.
  - Required: rom_ce_o=0 from cycle 5 on; count=4; inst_valid_o=1 with pc_o=0x0 from cycle 2 on.
- Streaming: inst_ready_i=1 from reset, ROM returns word = addr.
  - Required: pc_o/inst_o = 0x0, 0x4, 0x8, ... on consecutive cycles starting cycle 2; count stays at most 1.
- Full with pop: hold count=4, then pulse inst_ready_i=1 for one cycle.
  - Required: count=3 after that edge, with no push on that edge.
  - Required: next cycle rom_ce_o=1 at address 0x10, then count=4.
- Redirect: mid-stream, jump_i=1 with jump_addr_i=0x103.
  - Required: next cycle inst_valid_o=0, rom_ce_o=1, rom_addr_o=0x100.
  - Required: following cycle inst_valid_o=1, pc_o=0x100; no stale pre-jump PC ever appears on pc_o.
- PC wrap: RESET_PC=0xFFFFFFF8, inst_ready_i=1.
  - Required: fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004 in order.
- Asynchronous reset mid-operation: drive rst=0 between clock edges with count=3.
  - Required: inst_valid_o=0, rom_ce_o=0, pc_o=0 immediately, without waiting for a clock edge.
  - Required: after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_buffer_if.sv
// Fetch-side bus bundle: ROM request/response, redirect from execute, and the
// valid/ready instruction stream toward decode.
interface if_prefetch_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;
  logic              jump_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              inst_ready_i;

  modport slave (
    output rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o,
    input  rom_data_i, jump_i, jump_addr_i, inst_ready_i
  );

  modport master (
    input  rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o,
    output rom_data_i, jump_i, jump_addr_i, inst_ready_i
  );
endinterface

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch stage: owns the fetch PC, reads the ROM into a small
// {pc, inst} FIFO and hands entries to decode; a redirect flushes everything.
module if_prefetch_buffer #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  if_prefetch_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            entry_d, head;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push, pop, not_empty;

  always_comb begin
    not_empty  = (cnt_q != '0);
    // A full FIFO never fetches, even if decode pops in the same cycle.
    push       = rst & (cnt_q != FULL_CNT) & ~bus.jump_i;
    pop        = not_empty & bus.inst_ready_i & ~bus.jump_i;
    entry_d    = '{pc: fetch_pc_q, inst: bus.rom_data_i};
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    if (bus.jump_i) begin
      fetch_pc_d = bus.jump_addr_i & ~ADDR_W'(3);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  assign head             = not_empty ? mem_q[rd_ptr_q] : '0;
  assign bus.rom_ce_o     = push;
  assign bus.rom_addr_o   = fetch_pc_q;
  assign bus.inst_valid_o = not_empty;
  assign bus.inst_o       = head.inst;
  assign bus.pc_o         = head.pc;
endmodule
